tqvp_bus_initiator: RTL and testbench
=====================================

# tqvp_bus_initiator

Initiator-side master for the TinyQV peripheral bus, the counterpart to the memory-mapped `tqvp_*` peripherals. It accepts single read/write commands over a valid/ready command port and drives `address`/`data_write_n`/`data_read_n` toward one peripheral. It waits for `data_ready` on reads and returns read data or an error over a valid/ready response port. It serves as the host for bench bring-up and as the bridge for debug/command front-ends.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum READ-state cycles before a timeout error; legal range ≥1.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_size` in 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
- `cmd_addr` in 6: peripheral address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: read data, zero-extended to size; 0 for writes and errors.
- `rsp_err` out 1: illegal size, misalignment, or timeout.
- `bus_address` out 6: to peripheral `address`.
- `bus_wdata` out 32: to peripheral `data_in`.
- `bus_write_n` out 2: to peripheral `data_write_n`.
- `bus_read_n` out 2: to peripheral `data_read_n`.
- `bus_rdata` in 32: from peripheral `data_out`.
- `bus_ready` in 1: from peripheral `data_ready`.

## Operation
- States: IDLE, WRITE, READ, RESP.
- **IDLE**
  - `cmd_ready` = 1; strobes = 11.
  - On `cmd_valid`: latch the command.
  - If size = 11, or 16-bit with `addr[0]` ≠ 0, or 32-bit with `addr[1:0]` ≠ 0: go to RESP with `err` = 1 and `rdata` = 0. No bus activity.
  - Otherwise go to WRITE or READ.
- **WRITE**
  - Exactly one cycle: `bus_write_n` = size, `bus_address`/`bus_wdata` = latched values.
  - Next state RESP, `err` = 0, `rdata` = 0.
- **READ**
  - `bus_read_n` = size and `bus_address` held every cycle.
  - Timeout counter clears on entry.
  - `bus_ready` = 1 in a cycle: capture `bus_rdata` masked by size (8 → [7:0], 16 → [15:0], 32 → all), `err` = 0, go to RESP.
  - Otherwise the counter increments. In the `TIMEOUT_CYCLES`-th READ cycle with no ready: `err` = 1, `rdata` = 0, go to RESP.
  - Ready in the final cycle wins over timeout.
- **RESP**
  - `rsp_valid` = 1; `rsp_rdata`/`rsp_err` stable until `rsp_ready`. Then go to IDLE.
  - `cmd_ready` = 0 in every state except IDLE.
- Strobes are 11 outside WRITE/READ. `bus_address`/`bus_wdata` are 0 outside WRITE/READ.

## Timing
- Reset values: `cmd_ready` = 1 (IDLE), `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `bus_write_n` = `bus_read_n` = 11, `bus_address` = 0, `bus_wdata` = 0.
- `rst` in any state: next cycle is IDLE with reset values. Any in-flight transaction and response are discarded, and strobes drop to 11 immediately.
- All outputs are registered.
- Write latency: command accepted at edge N → strobe during cycle N+1 → `rsp_valid` from cycle N+2.
- Read latency: as for write when the peripheral has combinational `data_ready` = 1. Each cycle of ready-low adds one cycle.
- Error without bus: `rsp_valid` at N+1.
- Back-to-back: response accepted at edge M → `cmd_ready` = 1 at M+1. Peak throughput is one transaction per 3 cycles with zero backpressure.

## Structure
- Shared package `tqvp_bus_pkg`:
  - size encodings `SIZE_8`/`SIZE_16`/`SIZE_32`/`SIZE_NONE` (11);
  - `state_t` enum;
  - helper function `size_mask(size)`.
- Single module, no sub-module. The timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- **32-bit write:** write, size 10, addr 0x00, wdata 0x12345678 into the INTERCAL ALU peripheral. Required: one cycle of `bus_write_n` = 10 with address 0x00; `rsp_err` = 0, `rsp_rdata` = 0; a later 32-bit read at 0x00 with op selecting A returns 0x12345678.
- **16-bit read:** read, size 01, addr 0x02 against a stub returning 0xDEADBEEF. Required: `bus_read_n` = 01 for 1 cycle; `rsp_rdata` = 0x0000BEEF.
- **Stall:** stub holds `bus_ready` low 3 cycles, then high with 0xA5. Required: 4 READ cycles; `rsp_valid` at N+5; `rsp_rdata` = 0xA5 (8-bit read).
- **Timeout:** `TIMEOUT_CYCLES` = 4, ready never asserted. Required: exactly 4 cycles with `bus_read_n` ≠ 11; `rsp_err` = 1, `rsp_rdata` = 0.
- **Misaligned / illegal:** 32-bit read at 0x02, and size 11. Required: no strobe ever leaves 11; `rsp_err` = 1 at N+1.
- **Backpressure and reset:** `rsp_ready` low 5 cycles → `rsp_valid`/data stable, `cmd_ready` = 0 throughout. `rst` asserted mid-READ → strobes 11 and `rsp_valid` = 0 next cycle, `cmd_ready` = 1.

Source files
------------

// File: rtl/tqvp_bus_pkg.sv
// rtl/tqvp_bus_pkg.sv - shared encodings, state type and helpers for the TinyQV bus initiator
package tqvp_bus_pkg;

  localparam logic [1:0] SIZE_8    = 2'b00;
  localparam logic [1:0] SIZE_16   = 2'b01;
  localparam logic [1:0] SIZE_32   = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_8:  size_mask = 32'h0000_00FF;
      SIZE_16: size_mask = 32'h0000_FFFF;
      SIZE_32: size_mask = 32'hFFFF_FFFF;
      default: size_mask = 32'h0000_0000;
    endcase
  endfunction

  // Size must be encodable and the low address bits naturally aligned to it.
  function automatic logic size_addr_ok(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_8:  size_addr_ok = 1'b1;
      SIZE_16: size_addr_ok = (addr_lo[0] == 1'b0);
      SIZE_32: size_addr_ok = (addr_lo == 2'b00);
      default: size_addr_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_bus_initiator.sv
// rtl/tqvp_bus_initiator.sv - single-command initiator driving one TinyQV peripheral
module tqvp_bus_initiator
  import tqvp_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]       rsp_rdata_d, bus_wdata_d;
  logic [5:0]        bus_address_d;
  logic [1:0]        bus_write_n_d, bus_read_n_d;

  // Every output is computed for the next state and registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      size_q      <= SIZE_NONE;
      cnt_q       <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      bus_address <= 6'h0;
      bus_wdata   <= 32'h0;
      bus_write_n <= SIZE_NONE;
      bus_read_n  <= SIZE_NONE;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      bus_address <= bus_address_d;
      bus_wdata   <= bus_wdata_d;
      bus_write_n <= bus_write_n_d;
      bus_read_n  <= bus_read_n_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = 32'h0;
    rsp_err_d     = 1'b0;
    bus_address_d = 6'h0;
    bus_wdata_d   = 32'h0;
    bus_write_n_d = SIZE_NONE;
    bus_read_n_d  = SIZE_NONE;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          size_d      = cmd_size;
          if (!size_addr_ok(cmd_size, cmd_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (cmd_write) begin
            state_d       = ST_WRITE;
            bus_write_n_d = cmd_size;
            bus_address_d = cmd_addr;
            bus_wdata_d   = cmd_wdata;
          end else begin
            state_d       = ST_READ;
            cnt_d         = '0;
            bus_read_n_d  = cmd_size;
            bus_address_d = cmd_addr;
          end
        end
      end

      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end

      // Ready is checked before the timeout so a last-cycle ready still returns data.
      ST_READ: begin
        if (bus_ready) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_rdata & size_mask(size_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d         = cnt_q + 1'b1;
          bus_read_n_d  = size_q;
          bus_address_d = bus_address;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rsp_rdata;
          rsp_err_d   = rsp_err;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// tb/tb_tqvp_bus_initiator.sv - directed self-checking bench for tqvp_bus_initiator
module tb_tqvp_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  bus_address;
  logic [31:0] bus_wdata, bus_rdata;
  logic [1:0]  bus_write_n, bus_read_n;
  logic        bus_ready;

  int tests = 0;
  int fails = 0;

  // Peripheral stub: register A at address 0, otherwise a fixed read word.
  logic [31:0] reg_a = 32'h0;
  logic [31:0] stub_data = 32'h0;
  logic        sel_reg = 1'b0;
  logic        never_ready = 1'b0;
  int          stall_cfg = 0;
  int          rd_run = 0;

  int          wr_cycles = 0, rd_cycles = 0;
  logic [1:0]  last_wr_n = 2'b11, last_rd_n = 2'b11;
  logic [5:0]  last_wr_addr = 6'h3F;

  always #5 clk = ~clk;

  assign bus_rdata = sel_reg ? reg_a : stub_data;
  assign bus_ready = (bus_read_n != 2'b11) && !never_ready && (rd_run >= stall_cfg);

  always @(posedge clk) begin
    rd_run <= (bus_read_n != 2'b11) ? rd_run + 1 : 0;
    if (bus_write_n == 2'b10 && bus_address == 6'h00) reg_a <= bus_wdata;
    if (bus_write_n != 2'b11) begin
      wr_cycles    <= wr_cycles + 1;
      last_wr_n    <= bus_write_n;
      last_wr_addr <= bus_address;
    end
    if (bus_read_n != 2'b11) begin
      rd_cycles <= rd_cycles + 1;
      last_rd_n <= bus_read_n;
    end
  end

  tqvp_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_write_n(bus_write_n), .bus_read_n(bus_read_n),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge following the accepting edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic [5:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = d;
    check("cmd_ready_at_issue", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int lat, wr0, rd0;
    logic [31:0] held;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
    cmd_addr = 6'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_write_n", {30'b0, bus_write_n}, 32'd3);
    check("rst_read_n", {30'b0, bus_read_n}, 32'd3);
    check("rst_address", {26'b0, bus_address}, 32'd0);
    check("rst_wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 32-bit write to register A
    wr0 = wr_cycles;
    issue(1'b1, 2'b10, 6'h00, 32'h12345678);
    check("wr_strobe_n", {30'b0, bus_write_n}, 32'd2);
    check("wr_wdata", bus_wdata, 32'h12345678);
    wait_rsp(lat);
    check("wr_latency", lat, 32'd2);
    check("wr_cycles", wr_cycles - wr0, 32'd1);
    check("wr_last_n", {30'b0, last_wr_n}, 32'd2);
    check("wr_last_addr", {26'b0, last_wr_addr}, 32'd0);
    check("wr_err", {31'b0, rsp_err}, 32'd0);
    check("wr_rdata", rsp_rdata, 32'h0);
    accept_rsp("wr");

    // 32-bit read-back of register A
    sel_reg = 1'b1;
    issue(1'b0, 2'b10, 6'h00, 32'h0);
    wait_rsp(lat);
    check("rb_latency", lat, 32'd2);
    check("rb_rdata", rsp_rdata, 32'h12345678);
    accept_rsp("rb");
    sel_reg = 1'b0;

    // 16-bit read, masked
    stub_data = 32'hDEADBEEF;
    rd0 = rd_cycles;
    issue(1'b0, 2'b01, 6'h02, 32'h0);
    wait_rsp(lat);
    check("r16_latency", lat, 32'd2);
    check("r16_cycles", rd_cycles - rd0, 32'd1);
    check("r16_last_n", {30'b0, last_rd_n}, 32'd1);
    check("r16_rdata", rsp_rdata, 32'h0000BEEF);
    check("r16_err", {31'b0, rsp_err}, 32'd0);
    accept_rsp("r16");

    // 8-bit read with three stall cycles
    stub_data = 32'h123456A5; stall_cfg = 3;
    rd0 = rd_cycles;
    issue(1'b0, 2'b00, 6'h05, 32'h0);
    wait_rsp(lat);
    check("stall_latency", lat, 32'd5);
    check("stall_cycles", rd_cycles - rd0, 32'd4);
    check("stall_rdata", rsp_rdata, 32'h000000A5);
    accept_rsp("stall");
    stall_cfg = 0;

    // Timeout after exactly four READ cycles
    never_ready = 1'b1;
    rd0 = rd_cycles;
    issue(1'b0, 2'b10, 6'h04, 32'h0);
    wait_rsp(lat);
    check("to_latency", lat, 32'd5);
    check("to_cycles", rd_cycles - rd0, 32'd4);
    check("to_err", {31'b0, rsp_err}, 32'd1);
    check("to_rdata", rsp_rdata, 32'h0);
    accept_rsp("to");
    never_ready = 1'b0;

    // Misaligned 32-bit and illegal size: no bus activity
    wr0 = wr_cycles; rd0 = rd_cycles;
    issue(1'b0, 2'b10, 6'h02, 32'h0);
    check("mis_valid_n1", {31'b0, rsp_valid}, 32'd1);
    check("mis_err", {31'b0, rsp_err}, 32'd1);
    accept_rsp("mis");
    issue(1'b1, 2'b11, 6'h00, 32'hFFFFFFFF);
    check("ill_valid_n1", {31'b0, rsp_valid}, 32'd1);
    check("ill_err", {31'b0, rsp_err}, 32'd1);
    check("ill_rdata", rsp_rdata, 32'h0);
    accept_rsp("ill");
    check("err_no_strobes", (wr_cycles - wr0) + (rd_cycles - rd0), 32'd0);

    // Backpressure: response held for five cycles
    stub_data = 32'hCAFEF00D;
    issue(1'b0, 2'b10, 6'h08, 32'h0);
    wait_rsp(lat);
    held = rsp_rdata;
    check("bp_rdata", held, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_stable", rsp_rdata, 32'hCAFEF00D);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    accept_rsp("bp");

    // Reset in the middle of a READ
    never_ready = 1'b1;
    issue(1'b0, 2'b10, 6'h0C, 32'h0);
    check("mid_read_active", {30'b0, bus_read_n}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_read_n", {30'b0, bus_read_n}, 32'd3);
    check("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_mid_address", {26'b0, bus_address}, 32'd0);
    never_ready = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
